// File: rtl/latch_bank_arbiter.sv
// Arbiter/sequencer sharing one transparent latch bank among NREQ requesters with setup/open/hold guard windows.
// Optional macro LATCH_ARB_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module latch_bank_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WIDTH-1:0]   wdata_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [NREQ-1:0]         done_o,
    output logic [WIDTH-1:0]        latch_d_o,
    output logic                    latch_en_o,
    output logic                    busy_o
);
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MAXC = (SETUP_CYC > OPEN_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_OPEN, S_HOLD, S_DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     win_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic [WIDTH-1:0]  latch_d_q;
    logic              latch_en_q;
    logic              busy_q;
`ifdef LATCH_ARB_RR_EN
    logic [IW-1:0]     rr_ptr_q;
`endif

    logic [IW-1:0]     win_d;
    logic [NREQ-1:0]   gnt_d;
    logic [NREQ-1:0]   done_d;
    logic              found;
    int                idx;

    // Winner search over the candidate order; only consumed in IDLE.
    always_comb begin
        win_d = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef LATCH_ARB_RR_EN
            idx = (int'(rr_ptr_q) + k) % NREQ;
`else
            idx = k;
`endif
            if (!found && req_i[idx]) begin
                win_d = IW'(idx);
                found = 1'b1;
            end
        end
        gnt_d         = '0;
        gnt_d[win_d]  = 1'b1;
        done_d        = '0;
        done_d[win_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            win_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            latch_d_q  <= '0;
            latch_en_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef LATCH_ARB_RR_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= '0;
                    if (found) begin
                        state_q   <= S_SETUP;
                        cnt_q     <= SETUP_LD;
                        win_q     <= win_d;
                        gnt_q     <= gnt_d;
                        latch_d_q <= wdata_i[int'(win_d)*WIDTH +: WIDTH];
                        busy_q    <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_OPEN;
                        cnt_q      <= OPEN_LD;
                        latch_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_OPEN: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_HOLD;
                        cnt_q      <= HOLD_LD;
                        latch_en_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                        cnt_q   <= '0;
                        gnt_q   <= '0;
                        done_q  <= done_d;
`ifdef LATCH_ARB_RR_EN
                        rr_ptr_q <= (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt_o      = gnt_q;
    assign done_o     = done_q;
    assign latch_d_o  = latch_d_q;
    assign latch_en_o = latch_en_q;
    assign busy_o     = busy_q;

endmodule
